// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared state encoding and constants for the program loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          WORD_BYTES  = 4;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

`default_nettype wire

// File: rtl/byte_assembler.sv
// ============================================================================
// Module : byte_assembler
// Brief  : Packs accepted stream bytes into a little-endian 32-bit word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word;

  // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_idx  <= r_idx + IDX_W'(1);
      r_word <= {i_byte, r_word[31:8]};
    end
  end

  assign o_word          = r_word;
  assign o_word_complete = i_accept && (r_idx == IDX_W'(WORD_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Loads a byte stream into instruction memory, holding the CPU in
//          reset until done. Optional checksum: PROGRAM_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_ready,
  output logic             o_wr_en,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_cpu_reset_n,
  output logic [CNT_W-1:0] o_words_written
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH_WORDS);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_words_written;
  logic             r_byte_ready;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             r_cpu_reset_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;
  logic             r_chk_pend;
`endif

  logic             w_start_ok;
  logic             w_accept;
  logic [31:0]      w_word;
  logic             w_word_complete;
  logic [CNT_W-1:0] w_ww_next;

  assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept   = i_byte_valid && r_byte_ready;
  assign w_ww_next  = r_words_written + CNT_W'(1);

  byte_assembler u_asm (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_start_ok),
    .i_accept        (w_accept),
    .i_byte          (i_byte_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_words_written <= '0;
      r_byte_ready    <= 1'b0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= BASE_ADDR;
      r_wr_data       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_cpu_reset_n   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum           <= '0;
      r_chk_pend      <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (i_word_count == '0) begin
              r_state         <= ST_DONE;
              r_words_written <= '0;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
              r_error         <= 1'b0;
              r_cpu_reset_n   <= 1'b1;
            end else if (i_word_count > c_depth) begin
              r_state       <= ST_IDLE;
              r_done        <= 1'b0;
              r_error       <= 1'b1;
              r_cpu_reset_n <= 1'b0;
            end else begin
              r_state         <= ST_LOAD;
              r_count         <= i_word_count;
              r_words_written <= '0;
              r_byte_ready    <= 1'b1;
              r_busy          <= 1'b1;
              r_done          <= 1'b0;
              r_error         <= 1'b0;
              r_cpu_reset_n   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_sum           <= '0;
              r_chk_pend      <= 1'b0;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (w_word_complete) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_wr_en         <= 1'b1;
          r_wr_addr       <= BASE_ADDR + 32'(r_words_written) * ADDR_STRIDE;
          r_wr_data       <= w_word;
          r_words_written <= w_ww_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          r_sum           <= r_sum + w_word;
`endif
          if (w_ww_next == r_count) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_cpu_reset_n <= 1'b1;
`endif
          end else begin
            r_state      <= ST_LOAD;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Compare one cycle after the last checksum byte so the assembled word is settled.
        ST_CHECK: begin
          if (r_chk_pend) begin
            r_chk_pend    <= 1'b0;
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_error       <= (w_word != r_sum);
            r_cpu_reset_n <= (w_word == r_sum);
          end else if (w_word_complete) begin
            r_byte_ready <= 1'b0;
            r_chk_pend   <= 1'b1;
          end
        end
`endif
        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready    = r_byte_ready;
  assign o_wr_en         = r_wr_en;
  assign o_wr_addr       = r_wr_addr;
  assign o_wr_data       = r_wr_data;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_cpu_reset_n   = r_cpu_reset_n;
  assign o_words_written = r_words_written;

endmodule

`default_nettype wire
